// File: rtl/checkbits_seq_monitor.sv
// checkbits_seq_monitor: watches the firmware checkbits bus for a start
// marker, an ordered list of expected progress values and an end marker,
// measuring start-to-end latency and enforcing a global timeout. Outcome is
// reported as a sticky PASS/FAIL state with a failure code.
module checkbits_seq_monitor #(
  parameter int             W          = 16,
  parameter int             DEPTH      = 8,
  parameter int             LAT_W      = 32,
  parameter int             TO_W       = 32,
  parameter int             TIMEOUT    = 3000000,
  parameter int             STABLE     = 2,
  parameter logic [W-1:0]   START_MARK = W'(16'hAB40),
  parameter logic [W-1:0]   END_MARK   = W'(16'hAB51),
  parameter bit             STRICT     = 1'b0,
  localparam int            AW         = $clog2(DEPTH),
  localparam int            CW         = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic [W-1:0]     checkbits,
  input  logic             clear,
  input  logic             exp_we,
  input  logic [AW-1:0]    exp_addr,
  input  logic [W-1:0]     exp_data,
  input  logic [CW-1:0]    exp_count,
  output logic [1:0]       state,
  output logic             match,
  output logic [CW-1:0]    match_idx,
  output logic [LAT_W-1:0] latency,
  output logic             done,
  output logic             pass,
  output logic [2:0]       fail_code
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_PASS = 2'd2,
    S_FAIL = 2'd3
  } mon_state_t;

  localparam logic [3:0]      STABLE_V = 4'(STABLE);
  localparam logic [TO_W-1:0] TO_LIM   = TO_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  mon_state_t       cur_state;
  mon_state_t       nxt_state;
  logic [2:0]       nxt_fail;
  logic             match_hit;

  logic [W-1:0]     samp;
  logic [3:0]       run_cnt;
  logic [W-1:0]     last_qual;
  logic             have_last;
  logic             qual;

  logic [W-1:0]     tbl [DEPTH];
  logic [CW-1:0]    count_c;
  logic             to_hit;

  logic             match_q;
  logic [CW-1:0]    match_idx_q;
  logic [LAT_W-1:0] latency_q;
  logic [2:0]       fail_code_q;
  logic [TO_W-1:0]  to_cnt;

  // A value qualifies once after STABLE equal samples, and only if it differs
  // from the last qualified value, so a glitch back to the same value is inert.
  assign qual    = (run_cnt == STABLE_V) && (!have_last || (samp != last_qual));
  assign count_c = (exp_count > CW'(DEPTH)) ? CW'(DEPTH) : exp_count;
  assign to_hit  = (TIMEOUT != 0) && (to_cnt >= TO_LIM);

  // Input sampler and stability qualifier; clear restarts qualification.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      samp      <= '0;
      run_cnt   <= '0;
      last_qual <= '0;
      have_last <= 1'b0;
    end else if (clear) begin
      samp      <= '0;
      run_cnt   <= '0;
      last_qual <= '0;
      have_last <= 1'b0;
    end else begin
      samp <= checkbits;
      if ((run_cnt == 4'd0) || (checkbits != samp)) begin
        run_cnt <= 4'd1;
      end else if (run_cnt < STABLE_V) begin
        run_cnt <= run_cnt + 4'd1;
      end
      if (qual) begin
        last_qual <= samp;
        have_last <= 1'b1;
      end
    end
  end

  // Expected-value table; writes are blocked while a sequence is running.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl[i] <= '0;
      end
    end else if (exp_we && (cur_state != S_RUN)) begin
      tbl[exp_addr] <= exp_data;
    end
  end

  // State register; clear always returns to IDLE.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      cur_state <= S_IDLE;
    end else if (clear) begin
      cur_state <= S_IDLE;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // Next-state decision: end marker beats timeout, timeout beats matching.
  always_comb begin
    nxt_state = cur_state;
    nxt_fail  = fail_code_q;
    match_hit = 1'b0;
    case (cur_state)
      S_IDLE: begin
        if (qual && (samp == START_MARK)) begin
          nxt_state = S_RUN;
        end else if (to_hit) begin
          nxt_state = S_FAIL;
          nxt_fail  = 3'd2;
        end
      end
      S_RUN: begin
        if (qual && (samp == END_MARK)) begin
          if (match_idx_q == count_c) begin
            nxt_state = S_PASS;
          end else begin
            nxt_state = S_FAIL;
            nxt_fail  = 3'd3;
          end
        end else if (to_hit) begin
          nxt_state = S_FAIL;
          nxt_fail  = 3'd1;
        end else if (qual) begin
          if ((match_idx_q < count_c) && (samp == tbl[match_idx_q[AW-1:0]])) begin
            match_hit = 1'b1;
          end else if (STRICT && (samp != START_MARK)) begin
            nxt_state = S_FAIL;
            nxt_fail  = 3'd4;
          end
        end
      end
      default: begin
        nxt_state = cur_state;
      end
    endcase
  end

  // Progress, latency and timeout counters plus the registered match pulse.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      match_q     <= 1'b0;
      match_idx_q <= '0;
      latency_q   <= '0;
      fail_code_q <= '0;
      to_cnt      <= '0;
    end else if (clear) begin
      match_q     <= 1'b0;
      match_idx_q <= '0;
      latency_q   <= '0;
      fail_code_q <= '0;
      to_cnt      <= '0;
    end else begin
      match_q     <= match_hit;
      fail_code_q <= nxt_fail;
      if ((cur_state == S_IDLE) && (nxt_state == S_RUN)) begin
        latency_q   <= '0;
        match_idx_q <= '0;
      end else if (cur_state == S_RUN) begin
        if (latency_q != {LAT_W{1'b1}}) begin
          latency_q <= latency_q + LAT_W'(1);
        end
        if (match_hit) begin
          match_idx_q <= match_idx_q + CW'(1);
        end
      end
      if (((cur_state == S_IDLE) || (cur_state == S_RUN)) && (to_cnt != {TO_W{1'b1}})) begin
        to_cnt <= to_cnt + TO_W'(1);
      end
    end
  end

  // Status outputs decoded from the state register.
  always_comb begin
    state     = cur_state;
    done      = (cur_state == S_PASS) || (cur_state == S_FAIL);
    pass      = (cur_state == S_PASS);
    match     = match_q;
    match_idx = match_idx_q;
    latency   = latency_q;
    fail_code = fail_code_q;
  end

endmodule

// File: tb/tb_checkbits_seq_monitor.sv
// tb_checkbits_seq_monitor: directed bench for checkbits_seq_monitor using a
// vector table for whole sequences and hand-written timeout/clear/reset cases.
module tb_checkbits_seq_monitor;

  localparam int W  = 16;
  localparam int AW = 3;
  localparam int CW = 4;

  typedef struct {
    logic         clr;
    logic [W-1:0] value;
    int           hold;
    logic [1:0]   a_state;
    logic [CW-1:0] a_midx;
    int           a_pulses;
    logic [2:0]   a_fail;
    logic [1:0]   b_state;
    logic [2:0]   b_fail;
  } vec_t;

  logic          clock;
  logic          resetb;
  logic [W-1:0]  checkbits;
  logic          clear;
  logic          exp_we;
  logic [AW-1:0] exp_addr;
  logic [W-1:0]  exp_data;
  logic [CW-1:0] exp_count;

  logic [1:0]    a_state, b_state, c_state;
  logic          a_match, b_match, c_match;
  logic [CW-1:0] a_midx, b_midx, c_midx;
  logic [31:0]   a_lat, b_lat, c_lat;
  logic          a_done, b_done, c_done;
  logic          a_pass, b_pass, c_pass;
  logic [2:0]    a_fail, b_fail, c_fail;

  int   total;
  int   bad;
  int   cyc;
  int   pulses;
  vec_t vecs[14];

  checkbits_seq_monitor #(.TIMEOUT(1000), .STRICT(1'b0)) dut_a (
    .clock(clock), .resetb(resetb), .checkbits(checkbits), .clear(clear),
    .exp_we(exp_we), .exp_addr(exp_addr), .exp_data(exp_data), .exp_count(exp_count),
    .state(a_state), .match(a_match), .match_idx(a_midx), .latency(a_lat),
    .done(a_done), .pass(a_pass), .fail_code(a_fail)
  );

  checkbits_seq_monitor #(.TIMEOUT(1000), .STRICT(1'b1)) dut_b (
    .clock(clock), .resetb(resetb), .checkbits(checkbits), .clear(clear),
    .exp_we(exp_we), .exp_addr(exp_addr), .exp_data(exp_data), .exp_count(exp_count),
    .state(b_state), .match(b_match), .match_idx(b_midx), .latency(b_lat),
    .done(b_done), .pass(b_pass), .fail_code(b_fail)
  );

  checkbits_seq_monitor #(.TIMEOUT(100), .STRICT(1'b0)) dut_c (
    .clock(clock), .resetb(resetb), .checkbits(checkbits), .clear(clear),
    .exp_we(exp_we), .exp_addr(exp_addr), .exp_data(exp_data), .exp_count(exp_count),
    .state(c_state), .match(c_match), .match_idx(c_midx), .latency(c_lat),
    .done(c_done), .pass(c_pass), .fail_code(c_fail)
  );

  // Free-running clock, rising edge active.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Hard stop in case the sequence never reaches its summary.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 100000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      if (a_match === 1'b1) pulses++;
      cyc++;
    end
  endtask

  task automatic do_clear();
    checkbits = '0;
    clear     = 1'b1;
    @(negedge clock);
    clear     = 1'b0;
    cyc       = 0;
  endtask

  task automatic write_entry(input logic [AW-1:0] addr, input logic [W-1:0] data);
    exp_we   = 1'b1;
    exp_addr = addr;
    exp_data = data;
    @(negedge clock);
    exp_we   = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.clr) do_clear();
    checkbits = v.value;
    pulses    = 0;
    step(v.hold);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    cyc       = 0;
    pulses    = 0;
    resetb    = 1'b0;
    clear     = 1'b0;
    checkbits = '0;
    exp_we    = 1'b0;
    exp_addr  = '0;
    exp_data  = '0;
    exp_count = 4'd4;

    //             clr   value     hold st   midx pul fail  bst  bfail
    vecs[0]  = '{1'b1, 16'hAB40, 10, 2'd1, 4'd0, 0, 3'd0, 2'd1, 3'd0};
    vecs[1]  = '{1'b0, 16'h0062, 10, 2'd1, 4'd1, 1, 3'd0, 2'd1, 3'd0};
    vecs[2]  = '{1'b0, 16'h0068, 10, 2'd1, 4'd2, 1, 3'd0, 2'd1, 3'd0};
    vecs[3]  = '{1'b0, 16'h0074, 10, 2'd1, 4'd3, 1, 3'd0, 2'd1, 3'd0};
    vecs[4]  = '{1'b0, 16'h0080, 10, 2'd1, 4'd4, 1, 3'd0, 2'd1, 3'd0};
    vecs[5]  = '{1'b0, 16'hAB51, 10, 2'd2, 4'd4, 0, 3'd0, 2'd2, 3'd0};
    vecs[6]  = '{1'b1, 16'hAB40, 10, 2'd1, 4'd0, 0, 3'd0, 2'd1, 3'd0};
    vecs[7]  = '{1'b0, 16'h0062, 10, 2'd1, 4'd1, 1, 3'd0, 2'd1, 3'd0};
    vecs[8]  = '{1'b0, 16'h0068, 10, 2'd1, 4'd2, 1, 3'd0, 2'd1, 3'd0};
    vecs[9]  = '{1'b0, 16'hAB51, 10, 2'd3, 4'd2, 0, 3'd3, 2'd3, 3'd3};
    vecs[10] = '{1'b1, 16'hAB40, 10, 2'd1, 4'd0, 0, 3'd0, 2'd1, 3'd0};
    vecs[11] = '{1'b0, 16'h0062, 10, 2'd1, 4'd1, 1, 3'd0, 2'd1, 3'd0};
    vecs[12] = '{1'b0, 16'h0099, 10, 2'd1, 4'd1, 0, 3'd0, 2'd3, 3'd4};
    vecs[13] = '{1'b0, 16'h0068, 10, 2'd1, 4'd2, 1, 3'd0, 2'd3, 3'd4};

    // Reset values
    repeat (3) @(negedge clock);
    resetb = 1'b1;
    checkOutput("rst state",   32'(a_state), 32'd0);
    checkOutput("rst match",   32'(a_match), 32'd0);
    checkOutput("rst midx",    32'(a_midx),  32'd0);
    checkOutput("rst latency", a_lat,        32'd0);
    checkOutput("rst done",    32'(a_done),  32'd0);
    checkOutput("rst pass",    32'(a_pass),  32'd0);
    checkOutput("rst fail",    32'(a_fail),  32'd0);

    write_entry(3'd0, 16'h0062);
    write_entry(3'd1, 16'h0068);
    write_entry(3'd2, 16'h0074);
    write_entry(3'd3, 16'h0080);

    // Full sequences from the vector table
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("v%0d a_state", i),  32'(a_state), 32'(vecs[i].a_state));
      checkOutput($sformatf("v%0d a_midx", i),   32'(a_midx),  32'(vecs[i].a_midx));
      checkOutput($sformatf("v%0d a_pulses", i), 32'(pulses),  32'(vecs[i].a_pulses));
      checkOutput($sformatf("v%0d a_fail", i),   32'(a_fail),  32'(vecs[i].a_fail));
      checkOutput($sformatf("v%0d b_state", i),  32'(b_state), 32'(vecs[i].b_state));
      checkOutput($sformatf("v%0d b_fail", i),   32'(b_fail),  32'(vecs[i].b_fail));
      if (i == 5) begin
        checkOutput("pass latency", a_lat,       32'd50);
        checkOutput("pass flag",    32'(a_pass), 32'd1);
        checkOutput("pass done",    32'(a_done), 32'd1);
      end
    end

    // Glitch filtering: a single-cycle value never qualifies
    do_clear();
    checkbits = 16'hAB40;
    step(10);
    pulses    = 0;
    checkbits = 16'h0062;
    step(1);
    checkbits = 16'h1234;
    step(5);
    checkOutput("glitch pulses", 32'(pulses), 32'd0);
    checkOutput("glitch midx",   32'(a_midx), 32'd0);
    checkbits = 16'h0062;
    step(5);
    checkbits = 16'h1234;
    step(1);
    checkbits = 16'h0062;
    step(5);
    checkOutput("repeat pulses", 32'(pulses), 32'd1);
    checkOutput("repeat midx",   32'(a_midx), 32'd1);

    // Timeout while idle
    do_clear();
    step(99);
    checkOutput("to idle c99 state", 32'(c_state), 32'd0);
    step(1);
    checkOutput("to idle c100 state", 32'(c_state), 32'd3);
    checkOutput("to idle c100 fail",  32'(c_fail),  32'd2);

    // Timeout while running
    do_clear();
    step(9);
    checkbits = 16'hAB40;
    step(90);
    checkOutput("to run c99 state", 32'(c_state), 32'd1);
    step(1);
    checkOutput("to run c100 state", 32'(c_state), 32'd3);
    checkOutput("to run c100 fail",  32'(c_fail),  32'd1);

    // End marker qualifying on the timeout edge wins; empty table passes
    exp_count = 4'd0;
    do_clear();
    step(9);
    checkbits = 16'hAB40;
    step(88);
    checkbits = 16'hAB51;
    step(2);
    checkOutput("end-vs-to c99 state", 32'(c_state), 32'd1);
    step(1);
    checkOutput("end-vs-to state",   32'(c_state), 32'd2);
    checkOutput("end-vs-to pass",    32'(c_pass),  32'd1);
    checkOutput("end-vs-to fail",    32'(c_fail),  32'd0);
    checkOutput("end-vs-to latency", c_lat,        32'd88);
    checkOutput("empty table pass",  32'(a_state), 32'd2);

    // Clear out of PASS
    do_clear();
    checkOutput("clr state",   32'(a_state), 32'd0);
    checkOutput("clr done",    32'(a_done),  32'd0);
    checkOutput("clr pass",    32'(a_pass),  32'd0);
    checkOutput("clr fail",    32'(a_fail),  32'd0);
    checkOutput("clr latency", a_lat,        32'd0);
    checkOutput("clr midx",    32'(a_midx),  32'd0);

    // Asynchronous reset in the middle of a run
    exp_count = 4'd4;
    do_clear();
    checkbits = 16'hAB40;
    step(5);
    checkbits = 16'h0062;
    step(5);
    checkOutput("mid-run state",   32'(a_state), 32'd1);
    checkOutput("mid-run midx",    32'(a_midx),  32'd1);
    checkOutput("mid-run latency", a_lat,        32'd7);
    resetb = 1'b0;
    #1;
    checkOutput("async rst state",   32'(a_state), 32'd0);
    checkOutput("async rst midx",    32'(a_midx),  32'd0);
    checkOutput("async rst latency", a_lat,        32'd0);
    checkOutput("async rst done",    32'(a_done),  32'd0);
    @(negedge clock);
    resetb = 1'b1;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
